ysyx_040750_csr_regfile: RTL and testbench

YSYX_040750_CSR_REGFILE -- requirements
Module: ysyx_040750_csr_regfile

---
 rtl/ysyx_040750_csr_regfile.sv | 117 +++++++++++
 tb/tb_ysyx_040750_csr_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_csr_regfile.sv
// Machine-mode CSR register file: mstatus, mtvec, mscratch, mepc, mcause with trap/mret commit.
// Define YSYX_040750_MCYCLE_EN to add the free-running mcycle counter at 0xB00.
module ysyx_040750_csr_regfile #(
   parameter int DATA_W = 64
) (
   input  logic              I_sys_clk,
   input  logic              I_rst,
   input  logic [11:0]       I_csr_raddr_ID,
   output logic [DATA_W-1:0] O_csr_rdata_ID,
   input  logic              I_csr_wen_WB,
   input  logic [11:0]       I_csr_waddr_WB,
   input  logic [DATA_W-1:0] I_csr_wdata_WB,
   input  logic              I_trap_en,
   input  logic [DATA_W-1:0] I_trap_pc,
   input  logic [DATA_W-1:0] I_trap_cause,
   input  logic              I_mret_en,
   output logic [DATA_W-1:0] O_mtvec,
   output logic [DATA_W-1:0] O_mepc
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

   localparam logic [DATA_W-1:0] MSTATUS_RST = DATA_W'(64'h0000_000A_0000_1800);

   logic [DATA_W-1:0] mstatus, mtvec, mscratch, mepc, mcause;
   logic [DATA_W-1:0] mstatus_nxt, mtvec_nxt, mscratch_nxt, mepc_nxt, mcause_nxt;

   // WB writes first; trap/mret then override only the fields they own.
   always_comb begin
      mstatus_nxt  = mstatus;
      mtvec_nxt    = mtvec;
      mscratch_nxt = mscratch;
      mepc_nxt     = mepc;
      mcause_nxt   = mcause;

      if (I_csr_wen_WB) begin
         case (I_csr_waddr_WB)
            ADDR_MSTATUS:  mstatus_nxt  = I_csr_wdata_WB;
            ADDR_MTVEC:    mtvec_nxt    = {I_csr_wdata_WB[DATA_W-1:2], 2'b00};
            ADDR_MSCRATCH: mscratch_nxt = I_csr_wdata_WB;
            ADDR_MEPC:     mepc_nxt     = {I_csr_wdata_WB[DATA_W-1:1], 1'b0};
            ADDR_MCAUSE:   mcause_nxt   = I_csr_wdata_WB;
            default: ;
         endcase
      end

      if (I_trap_en) begin
         mepc_nxt              = {I_trap_pc[DATA_W-1:1], 1'b0};
         mcause_nxt            = I_trap_cause;
         mstatus_nxt[7]        = mstatus[3];
         mstatus_nxt[3]        = 1'b0;
         mstatus_nxt[12:11]    = 2'b11;
      end else if (I_mret_en) begin
         mstatus_nxt[3]        = mstatus[7];
         mstatus_nxt[7]        = 1'b1;
         mstatus_nxt[12:11]    = 2'b11;
      end
   end

   always_ff @(posedge I_sys_clk or posedge I_rst) begin
      if (I_rst) begin
         mstatus  <= MSTATUS_RST;
         mtvec    <= '0;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
      end else begin
         mstatus  <= mstatus_nxt;
         mtvec    <= mtvec_nxt;
         mscratch <= mscratch_nxt;
         mepc     <= mepc_nxt;
         mcause   <= mcause_nxt;
      end
   end

`ifdef YSYX_040750_MCYCLE_EN
   logic [DATA_W-1:0] mcycle;
   logic [DATA_W-1:0] mcycle_nxt;

   // A WB write replaces the increment for that cycle.
   always_comb begin
      mcycle_nxt = mcycle + DATA_W'(1);
      if (I_csr_wen_WB && (I_csr_waddr_WB == ADDR_MCYCLE))
         mcycle_nxt = I_csr_wdata_WB;
   end

   always_ff @(posedge I_sys_clk or posedge I_rst) begin
      if (I_rst) mcycle <= '0;
      else       mcycle <= mcycle_nxt;
   end
`endif

   // Read path has no bypass; the forwarding stage resolves same-cycle writes.
   always_comb begin
      O_csr_rdata_ID = '0;
      case (I_csr_raddr_ID)
         ADDR_MSTATUS:  O_csr_rdata_ID = mstatus;
         ADDR_MTVEC:    O_csr_rdata_ID = mtvec;
         ADDR_MSCRATCH: O_csr_rdata_ID = mscratch;
         ADDR_MEPC:     O_csr_rdata_ID = mepc;
         ADDR_MCAUSE:   O_csr_rdata_ID = mcause;
`ifdef YSYX_040750_MCYCLE_EN
         ADDR_MCYCLE:   O_csr_rdata_ID = mcycle;
`endif
         default:       O_csr_rdata_ID = '0;
      endcase
   end

   assign O_mtvec = mtvec;
   assign O_mepc  = mepc;

endmodule

// File: tb/tb_ysyx_040750_csr_regfile.sv
// Self-checking bench for ysyx_040750_csr_regfile: directed table, hand sequences and random traffic
// against an array-based reference model. Honours YSYX_040750_MCYCLE_EN like the design.
module tb_ysyx_040750_csr_regfile;

   logic        clk;
   logic        rst;
   logic [11:0] raddr;
   logic [63:0] rdata;
   logic        wen;
   logic [11:0] waddr;
   logic [63:0] wdata;
   logic        trap;
   logic [63:0] tpc;
   logic [63:0] tcause;
   logic        mret;
   logic [63:0] mtvec_o;
   logic [63:0] mepc_o;

   int total = 0;
   int bad   = 0;

   ysyx_040750_csr_regfile dut (
      .I_sys_clk      (clk),
      .I_rst          (rst),
      .I_csr_raddr_ID (raddr),
      .O_csr_rdata_ID (rdata),
      .I_csr_wen_WB   (wen),
      .I_csr_waddr_WB (waddr),
      .I_csr_wdata_WB (wdata),
      .I_trap_en      (trap),
      .I_trap_pc      (tpc),
      .I_trap_cause   (tcause),
      .I_mret_en      (mret),
      .O_mtvec        (mtvec_o),
      .O_mepc         (mepc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one array slot per architected CSR, addressed by name table.
   localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;
   logic [11:0] csr_addr [0:5];
   logic [63:0] mm [0:5];
`ifdef YSYX_040750_MCYCLE_EN
   localparam bit HAS_MCYCLE = 1'b1;
`else
   localparam bit HAS_MCYCLE = 1'b0;
`endif

   function automatic int slot(input logic [11:0] a);
      for (int k = 0; k < 6; k++)
         if (csr_addr[k] == a && (k != 5 || HAS_MCYCLE)) return k;
      return -1;
   endfunction

   function automatic logic [63:0] model_rd(input logic [11:0] a);
      int s;
      s = slot(a);
      if (s < 0) return 64'h0;
      return mm[s];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 6; k++) mm[k] = 64'h0;
      mm[0] = MSTATUS_RST;
   endtask

   task automatic model_step();
      logic [63:0] nx [0:5];
      logic [63:0] v;
      int s;
      if (rst) begin
         model_reset();
         return;
      end
      nx = mm;
      nx[5] = mm[5] + 64'd1;
      s = slot(waddr);
      if (wen && s >= 0) begin
         v = wdata;
         if (waddr == 12'h305) v = v & ~64'h3;
         if (waddr == 12'h341) v = v & ~64'h1;
         nx[s] = v;
      end
      if (trap) begin
         nx[3] = tpc & ~64'h1;
         nx[4] = tcause;
         v = nx[0];
         v[7] = mm[0][3];
         v[3] = 1'b0;
         v[12:11] = 2'b11;
         nx[0] = v;
      end else if (mret) begin
         v = nx[0];
         v[3] = mm[0][7];
         v[7] = 1'b1;
         v[12:11] = 2'b11;
         nx[0] = v;
      end
      mm = nx;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Advance one clock: model follows the edge, then return to the falling edge for driving.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wen = 1'b0; waddr = 12'h0; wdata = 64'h0;
      trap = 1'b0; tpc = 64'h0; tcause = 64'h0; mret = 1'b0;
   endtask

   typedef struct {
      logic        wen;
      logic [11:0] waddr;
      logic [63:0] wdata;
      logic        trap;
      logic [63:0] pc;
      logic [63:0] cause;
      logic        mret;
      logic [11:0] raddr;
      logic [63:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [11:0] wa, input logic [63:0] wd,
                               input logic t, input logic [63:0] pc, input logic [63:0] ca,
                               input logic m, input logic [11:0] ra, input logic [63:0] ex);
      vec_t r;
      r.wen = w; r.waddr = wa; r.wdata = wd; r.trap = t; r.pc = pc; r.cause = ca;
      r.mret = m; r.raddr = ra; r.exp = ex;
      return r;
   endfunction

   vec_t vecs [0:13];
   logic [11:0] rlist [0:6];

   initial begin
      csr_addr[0] = 12'h300; csr_addr[1] = 12'h305; csr_addr[2] = 12'h340;
      csr_addr[3] = 12'h341; csr_addr[4] = 12'h342; csr_addr[5] = 12'hB00;
      rlist[0] = 12'h300; rlist[1] = 12'h305; rlist[2] = 12'h340; rlist[3] = 12'h341;
      rlist[4] = 12'h342; rlist[5] = 12'hB00; rlist[6] = 12'h7C0;

      vecs[0]  = mk(1, 12'h300, 64'h8, 0, 0, 0, 0, 12'h300, 64'h8);
      vecs[1]  = mk(0, 0, 0, 1, 64'h8000_0104, 64'd11, 0, 12'h341, 64'h8000_0104);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h342, 64'd11);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h300, 64'h1880);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h1888);
      vecs[5]  = mk(1, 12'h341, 64'h55, 1, 64'h8000_0200, 64'd2, 1, 12'h341, 64'h8000_0200);
      vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h300, 64'h1880);
      vecs[7]  = mk(1, 12'h340, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, 0, 12'h340, 64'hDEAD_BEEF_1234_5678);
      vecs[8]  = mk(1, 12'h341, 64'h1001, 0, 0, 0, 0, 12'h341, 64'h1000);
      vecs[9]  = mk(1, 12'h7C0, 64'hFF, 0, 0, 0, 0, 12'h7C0, 64'h0);
      vecs[10] = mk(1, 12'h300, 64'hFFFF_0000_0000_0000, 0, 0, 0, 1, 12'h300, 64'hFFFF_0000_0000_1888);
      vecs[11] = mk(1, 12'h305, 64'h8000_1001, 1, 64'h8000_0303, 64'h8000_0000_0000_0007, 0,
                    12'h305, 64'h8000_1000);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 12'h341, 64'h8000_0302);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 12'h300, 64'hFFFF_0000_0000_1880);

      // Reset state, checked while reset is still held.
      rst = 1'b1;
      raddr = 12'h300;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         raddr = csr_addr[k];
         #1 chk($sformatf("rst_rd_%h", csr_addr[k]), rdata, (k == 0) ? MSTATUS_RST : 64'h0);
      end
      chk("rst_mtvec", mtvec_o, 64'h0);
      chk("rst_mepc", mepc_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // mtvec write: old value visible during the write cycle, aligned value afterwards.
      wen = 1'b1; waddr = 12'h305; wdata = 64'h8000_0003; raddr = 12'h305;
      #1 chk("mtvec_same_cycle", rdata, 64'h0);
      tick();
      idle_inputs();
      #1 chk("mtvec_out", mtvec_o, 64'h8000_0000);

      // Directed table.
      for (int i = 0; i < 14; i++) begin
         wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         trap = vecs[i].trap; tpc = vecs[i].pc; tcause = vecs[i].cause; mret = vecs[i].mret;
         raddr = vecs[i].raddr;
         #1 chk($sformatf("vec%0d_pre_rd", i), rdata, model_rd(raddr));
         tick();
         idle_inputs();
         #1;
         chk($sformatf("vec%0d_rd", i), rdata, vecs[i].exp);
         chk($sformatf("vec%0d_mepc", i), mepc_o, mm[3]);
      end

      // mcycle wrap, or 0xB00 inert without the counter.
`ifdef YSYX_040750_MCYCLE_EN
      wen = 1'b1; waddr = 12'hB00; wdata = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      idle_inputs();
      raddr = 12'hB00;
      #1 chk("mcycle_fe", rdata, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      #1 chk("mcycle_ff", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      #1 chk("mcycle_wrap", rdata, 64'h0);
`else
      wen = 1'b1; waddr = 12'hB00; wdata = 64'h5;
      tick();
      idle_inputs();
      raddr = 12'hB00;
      #1 chk("b00_absent", rdata, 64'h0);
`endif

      // Random traffic against the model; reads are checked before each edge.
      for (int n = 0; n < 400; n++) begin
         wen    = ($urandom_range(0, 2) != 0);
         waddr  = rlist[$urandom_range(0, 6)];
         wdata  = {$urandom, $urandom};
         trap   = ($urandom_range(0, 7) == 0);
         tpc    = {$urandom, $urandom};
         tcause = {$urandom, $urandom};
         mret   = ($urandom_range(0, 5) == 0);
         raddr  = rlist[$urandom_range(0, 6)];
         #1;
         chk("rnd_rd", rdata, model_rd(raddr));
         chk("rnd_mtvec", mtvec_o, mm[1]);
         chk("rnd_mepc", mepc_o, mm[3]);
         tick();
      end
      idle_inputs();

      // Make mstatus/mepc distinct from reset, then reset asynchronously mid trap cycle.
      wen = 1'b1; waddr = 12'h341; wdata = 64'h1234;
      tick();
      idle_inputs();
      trap = 1'b1; tpc = 64'h8000_0404; tcause = 64'd3;
      #2 rst = 1'b1;
      raddr = 12'h300;
      #1;
      chk("arst_mstatus", rdata, MSTATUS_RST);
      chk("arst_mepc", mepc_o, 64'h0);
      chk("arst_mtvec", mtvec_o, 64'h0);
      model_reset();
      tick();
      idle_inputs();
      rst = 1'b0;
      raddr = 12'h342;
      #1 chk("arst_mcause", rdata, 64'h0);
      raddr = 12'h341;
      #1 chk("arst_no_trap", rdata, 64'h0);
      tick();
      raddr = 12'h300;
      #1 chk("post_rst_mstatus", rdata, model_rd(12'h300));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
